// File: rtl/sprite_lane_renderer.sv
// Multi-lane moving-sprite pixel generator: per-lane solid rectangles advanced once per frame,
// hit-tested against the VGA scan position with one cycle of output latency.
module sprite_lane_renderer #(
  parameter int unsigned NUM_LANES  = 3,
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned SPEED_W    = 4,
  parameter int unsigned SPRITE_W   = 25,
  parameter int unsigned SPRITE_H   = 25,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned LANE_Y0    = 100,
  parameter int unsigned LANE_PITCH = 200,
  parameter logic [NUM_LANES*12-1:0] LANE_RGB = {NUM_LANES{12'h0F0}},
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           vga_vs,
  input  logic [COORD_W-1:0]             xcount,
  input  logic [COORD_W-1:0]             ycount,
  input  logic [NUM_LANES-1:0]           lane_en,
  input  logic [NUM_LANES*SPEED_W-1:0]   lane_speed,
  output logic [3:0]                     vga_r,
  output logic [3:0]                     vga_g,
  output logic [3:0]                     vga_b,
  output logic                           hit,
  output logic                           frame_tick
);

  localparam int unsigned SW = COORD_W + 1;

  logic               vs_q, vs_d;
  logic               arm_q, arm_d;
  logic               frame_tick_q, frame_tick_d;
  logic               hit_q, hit_d;
  logic [11:0]        rgb_q, rgb_d;
  logic [COORD_W-1:0] head_q [NUM_LANES];
  logic [COORD_W-1:0] head_d [NUM_LANES];

  logic [SW-1:0]      sum, right, x_ext;
  logic               blank, found, y_in;
  int unsigned        top;

  always_comb begin
    vs_d  = vga_vs;
    arm_d = 1'b1;
    // arm_q blocks the first sampled cycle after reset, so a vga_vs already
    // low at release is not mistaken for a falling edge against vs_q=1.
    frame_tick_d = arm_q & vs_q & ~vga_vs;

    sum = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      head_d[i] = head_q[i];
      sum = {1'b0, head_q[i]} + SW'(lane_speed[i*SPEED_W +: SPEED_W]);
      if (frame_tick_q && lane_en[i]) begin
        head_d[i] = (sum >= SW'(H_ACTIVE)) ? COORD_W'(sum - SW'(H_ACTIVE))
                                            : sum[COORD_W-1:0];
      end
    end

    x_ext = {1'b0, xcount};
    blank = (xcount >= COORD_W'(H_ACTIVE)) || (ycount >= COORD_W'(V_ACTIVE));
    found = 1'b0;
    hit_d = 1'b0;
    rgb_d = blank ? '0 : BG_RGB;
    right = '0;
    top   = 0;
    y_in  = 1'b0;
    // Ascending scan with a found flag gives the lowest-index lane priority.
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      right = {1'b0, head_q[i]} + SW'(SPRITE_W - 1);
      top   = LANE_Y0 + i * LANE_PITCH;
      y_in  = (32'(ycount) >= top) && (32'(ycount) <= top + SPRITE_H - 1);
      if (!found && !blank && lane_en[i] && y_in &&
          (x_ext >= {1'b0, head_q[i]}) && (x_ext <= right)) begin
        found = 1'b1;
        hit_d = 1'b1;
        rgb_d = LANE_RGB[i*12 +: 12];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b1;
      arm_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      hit_q        <= 1'b0;
      rgb_q        <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) head_q[i] <= '0;
    end else begin
      vs_q         <= vs_d;
      arm_q        <= arm_d;
      frame_tick_q <= frame_tick_d;
      hit_q        <= hit_d;
      rgb_q        <= rgb_d;
      for (int unsigned i = 0; i < NUM_LANES; i++) head_q[i] <= head_d[i];
    end
  end

  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign hit        = hit_q;
  assign frame_tick = frame_tick_q;

endmodule
